// File: rtl/de0_lt24_sopc_pkg.sv
// Shared SOPC definitions: PIO register map, Avalon-MM command payload, sizing helper.
package de0_lt24_sopc_pkg;

    localparam int unsigned AVS_AW = 2;
    localparam int unsigned AVS_DW = 32;

    localparam logic [AVS_AW-1:0] ADDR_DATA    = 2'd0;
    localparam logic [AVS_AW-1:0] ADDR_RSVD    = 2'd1;
    localparam logic [AVS_AW-1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [AVS_AW-1:0] ADDR_EDGECAP = 2'd3;

    typedef struct packed {
        logic [AVS_AW-1:0] address;
        logic              wr;
        logic [AVS_DW-1:0] writedata;
    } avs_cmd_t;

    // Debounce counter width; at least one bit even for a single-cycle filter.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/de0_lt24_sopc_debounce.sv
// One-bit input conditioner: 2-flop synchronizer, stability counter, accepted level.
// rise_c flags the edge on which the accepted level goes 0->1.
module de0_lt24_sopc_debounce
    import de0_lt24_sopc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic stable_o,
    output logic rise_c
);

    localparam int unsigned            CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive disagreeing cycles; accept the new level on the last one.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= din_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_c   = stable_d & ~stable_q;

endmodule

// File: rtl/de0_lt24_sopc_pio_in.sv
// Debounced input PIO with Avalon-MM slave: DATA, IRQMASK and rising-edge
// capture registers, level interrupt from masked captures.
module de0_lt24_sopc_pio_in
    import de0_lt24_sopc_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    avs_cmd_t         cmd_c;
    logic             unused_wdata;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] clr_c;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;

    assign cmd_c        = '{address: address, wr: chipselect & ~write_n, writedata: writedata};
    assign unused_wdata = ^cmd_c.writedata;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        de0_lt24_sopc_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .reset    (reset),
            .din_i    (in_port[i]),
            .stable_o (stable[i]),
            .rise_c   (rise_c[i])
        );
    end

    // A capture arriving on the same edge as its write-1-clear wins.
    always_comb begin
        irqmask_d = irqmask_q;
        clr_c     = '0;
        if (cmd_c.wr && cmd_c.address == ADDR_IRQMASK) begin
            irqmask_d = cmd_c.writedata[WIDTH-1:0];
        end
        if (cmd_c.wr && cmd_c.address == ADDR_EDGECAP) begin
            clr_c = cmd_c.writedata[WIDTH-1:0];
        end
        edgecap_d = (edgecap_q & ~clr_c) | rise_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    // Zero-wait-state read mux; reads never disturb state.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(stable);
            ADDR_RSVD:    readdata = '0;
            ADDR_IRQMASK: readdata = 32'(irqmask_q);
            ADDR_EDGECAP: readdata = 32'(edgecap_q);
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule
